multiplier32_seq: RTL

//   Iterative shift-add multiplier: 32x32 -> 64-bit product, one multiplier bit per cycle.

---
 rtl/multiplier32_seq_pkg.sv | 22 ++
 rtl/multiplier32_seq_if.sv | 28 ++
 rtl/multiplier32_seq_adder32.sv | 22 ++
 rtl/multiplier32_seq.sv | 133 +++++++++++++
 4 files changed

// File: rtl/multiplier32_seq_pkg.sv
// Shared definitions for the iterative shift-add multiplier.
// Optional feature: MUL_SIGNED_EN (signed operands via magnitude/negate).
package multiplier32_seq_pkg;

  localparam int MUL_WIDTH = 32;
  localparam int CNT_W     = 5;

  // Control FSM encoding; ST_NEG is only reachable when MUL_SIGNED_EN is defined.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_NEG  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Two's-complement magnitude; 0x80000000 maps to itself, which is the
  // correct unsigned magnitude.
  function automatic logic [MUL_WIDTH-1:0] mag_of(input logic [MUL_WIDTH-1:0] v);
    return v[MUL_WIDTH-1] ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/multiplier32_seq_if.sv
// Operand/product handshake bundle for multiplier32_seq.
// Optional feature: MUL_SIGNED_EN adds the is_signed request bit.
interface multiplier32_seq_if;
  import multiplier32_seq_pkg::*;

  logic                   in_valid;
  logic                   in_ready;
  logic [MUL_WIDTH-1:0]   operand_a;
  logic [MUL_WIDTH-1:0]   operand_b;
  logic                   out_valid;
  logic                   out_ready;
  logic [2*MUL_WIDTH-1:0] product;
  logic                   busy;
`ifdef MUL_SIGNED_EN
  logic                   is_signed;

  modport master (output in_valid, operand_a, operand_b, is_signed, out_ready,
                  input  in_ready, out_valid, product, busy);
  modport slave  (input  in_valid, operand_a, operand_b, is_signed, out_ready,
                  output in_ready, out_valid, product, busy);
`else
  modport master (output in_valid, operand_a, operand_b, out_ready,
                  input  in_ready, out_valid, product, busy);
  modport slave  (input  in_valid, operand_a, operand_b, out_ready,
                  output in_ready, out_valid, product, busy);
`endif

endinterface

// File: rtl/multiplier32_seq_adder32.sv
// 32-bit ripple-carry adder used for the multiplier's partial-sum add.
module multiplier32_seq_adder32 (
  input  logic [31:0] operand1,
  input  logic [31:0] operand2,
  input  logic        carry_in,
  output logic [31:0] result,
  output logic        carry_out
);

  logic [32:0] w_carry;

  assign w_carry[0] = carry_in;

  for (genvar i = 0; i < 32; i++) begin : g_fa
    assign result[i]    = operand1[i] ^ operand2[i] ^ w_carry[i];
    assign w_carry[i+1] = (operand1[i] & operand2[i]) |
                          (w_carry[i] & (operand1[i] ^ operand2[i]));
  end

  assign carry_out = w_carry[32];

endmodule

// File: rtl/multiplier32_seq.sv
// Iterative shift-add multiplier, 32x32 -> 64, one multiplier bit per cycle.
// Optional feature: MUL_SIGNED_EN (is_signed input, extra NEG state, latency WIDTH+1).
module multiplier32_seq
  import multiplier32_seq_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic             clk,
  input  logic             resetn,
  multiplier32_seq_if.slave bus
);

  if (WIDTH != MUL_WIDTH) begin : g_width_check
    $error("multiplier32_seq: WIDTH must be %0d", MUL_WIDTH);
  end

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [CNT_W-1:0]       r_cnt;
  logic [MUL_WIDTH-1:0]   r_mcand;
  logic [2*MUL_WIDTH-1:0] r_acc;
  logic [2*MUL_WIDTH-1:0] r_product;
  logic [2*MUL_WIDTH-1:0] w_acc_nxt;
  logic [MUL_WIDTH-1:0]   w_add_b;
  logic [MUL_WIDTH-1:0]   w_sum;
  logic                   w_carry;
  logic                   w_accept;
  logic                   w_run_last;
  logic                   w_run_to_done;
`ifdef MUL_SIGNED_EN
  logic                   r_signed;
  logic                   r_sign;
`endif

  assign w_accept   = (r_state == ST_IDLE) && bus.in_valid;
  assign w_run_last = (r_state == ST_RUN) && (r_cnt == LAST_CNT);
`ifdef MUL_SIGNED_EN
  assign w_run_to_done = w_run_last && !r_signed;
`else
  assign w_run_to_done = w_run_last;
`endif

  // Partial sum: upper half of acc plus the multiplicand gated by the current multiplier bit.
  assign w_add_b = r_acc[0] ? r_mcand : '0;

  multiplier32_seq_adder32 u_adder (
    .operand1  (r_acc[2*MUL_WIDTH-1:MUL_WIDTH]),
    .operand2  (w_add_b),
    .carry_in  (1'b0),
    .result    (w_sum),
    .carry_out (w_carry)
  );

  // The 33-bit sum shifted right by one keeps carry_out as the new top bit.
  assign w_acc_nxt = {w_carry, w_sum, r_acc[MUL_WIDTH-1:1]};

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of process evaluation order.
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assigned first so every path drives the signal and no latch is inferred.
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (w_accept)        w_state_nxt = ST_RUN;
      ST_RUN:  if (w_run_to_done)   w_state_nxt = ST_DONE;
               else if (w_run_last) w_state_nxt = ST_NEG;
      ST_NEG:                       w_state_nxt = ST_DONE;
      ST_DONE: if (bus.out_ready)   w_state_nxt = ST_IDLE;
      default:                      w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: operand capture, shift-add iteration, counter and result register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt     <= '0;
      r_mcand   <= '0;
      r_acc     <= '0;
      r_product <= '0;
`ifdef MUL_SIGNED_EN
      r_signed  <= 1'b0;
      r_sign    <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_cnt <= '0;
`ifdef MUL_SIGNED_EN
            r_signed <= bus.is_signed;
            r_sign   <= bus.is_signed &
                        (bus.operand_a[MUL_WIDTH-1] ^ bus.operand_b[MUL_WIDTH-1]);
            r_mcand  <= bus.is_signed ? mag_of(bus.operand_a) : bus.operand_a;
            r_acc    <= {{MUL_WIDTH{1'b0}},
                         (bus.is_signed ? mag_of(bus.operand_b) : bus.operand_b)};
`else
            r_mcand  <= bus.operand_a;
            r_acc    <= {{MUL_WIDTH{1'b0}}, bus.operand_b};
`endif
          end
        end
        ST_RUN: begin
          r_acc <= w_acc_nxt;
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_run_to_done) r_product <= w_acc_nxt;
        end
`ifdef MUL_SIGNED_EN
        ST_NEG: begin
          r_product <= r_sign ? (~r_acc + 1'b1) : r_acc;
        end
`endif
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == ST_IDLE);
  assign bus.out_valid = (r_state == ST_DONE);
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.product   = r_product;

endmodule
